// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp timer and msip software interrupt,
// reached through a single-cycle word-wide request/response port.
`ifndef XLEN
`define XLEN 32
`endif

module clint #(
    parameter int unsigned TICK_DIV  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req,
    input  logic              write,
    input  logic [`XLEN-1:0]  addr,
    input  logic [`XLEN-1:0]  wdata,
    output logic              rsp_valid,
    output logic [`XLEN-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic              software_interrupt,
    output logic              timer_interrupt
);

    localparam int unsigned     CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    localparam logic [15:0] OFF_MSIP     = 16'h0000;
    localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
    localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
    localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
    localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

    logic [CNT_W-1:0] presc_r;
    logic [CNT_W-1:0] presc_nxt_s;
    logic             tick_s;
    logic [63:0]      mtime_r;
    logic [63:0]      mtime_nxt_s;
    logic [63:0]      mtimecmp_r;
    logic [63:0]      mtimecmp_nxt_s;
    logic             msip_r;
    logic             msip_nxt_s;
    logic [31:0]      off_s;
    logic [15:0]      reg_off_s;
    logic             in_win_s;
    logic             sel_msip_s;
    logic             sel_cmp_lo_s;
    logic             sel_cmp_hi_s;
    logic             sel_mt_lo_s;
    logic             sel_mt_hi_s;
    logic             hit_s;
    logic             wr_s;
    logic [31:0]      rdata_s;
    logic             unused_addr_s;
    logic             rsp_valid_r;
    logic             rsp_err_r;
    logic [31:0]      rsp_rdata_r;
    logic             tmr_irq_r;

    // Offset relative to the block base; the window test works for any BASE_ADDR.
    assign off_s         = addr - BASE_ADDR;
    assign in_win_s      = (off_s[31:16] == 16'h0000);
    assign reg_off_s     = {off_s[15:2], 2'b00};
    assign unused_addr_s = ^off_s[1:0];
    assign tick_s        = (presc_r == CNT_LAST);
    assign wr_s          = req & write;

    // Register decode inside the 64 KB window.
    always_comb begin
        sel_msip_s   = 1'b0;
        sel_cmp_lo_s = 1'b0;
        sel_cmp_hi_s = 1'b0;
        sel_mt_lo_s  = 1'b0;
        sel_mt_hi_s  = 1'b0;
        if (in_win_s) begin
            case (reg_off_s)
                OFF_MSIP:     sel_msip_s   = 1'b1;
                OFF_CMP_LO:   sel_cmp_lo_s = 1'b1;
                OFF_CMP_HI:   sel_cmp_hi_s = 1'b1;
                OFF_MTIME_LO: sel_mt_lo_s  = 1'b1;
                OFF_MTIME_HI: sel_mt_hi_s  = 1'b1;
                default:      sel_msip_s   = 1'b0;
            endcase
        end else begin
            sel_msip_s = 1'b0;
        end
    end

    assign hit_s = sel_msip_s | sel_cmp_lo_s | sel_cmp_hi_s | sel_mt_lo_s | sel_mt_hi_s;

    // Read mux sees the pre-update register values.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (sel_msip_s) begin
            rdata_s = {31'h0000_0000, msip_r};
        end else if (sel_cmp_lo_s) begin
            rdata_s = mtimecmp_r[31:0];
        end else if (sel_cmp_hi_s) begin
            rdata_s = mtimecmp_r[63:32];
        end else if (sel_mt_lo_s) begin
            rdata_s = mtime_r[31:0];
        end else if (sel_mt_hi_s) begin
            rdata_s = mtime_r[63:32];
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Next-state for prescaler and registers; a bus write to mtime beats a tick.
    always_comb begin
        presc_nxt_s    = tick_s ? CNT_W'(0) : (presc_r + CNT_W'(1));
        mtime_nxt_s    = mtime_r;
        mtimecmp_nxt_s = mtimecmp_r;
        msip_nxt_s     = msip_r;
        if (wr_s && sel_mt_lo_s) begin
            mtime_nxt_s = {mtime_r[63:32], wdata};
        end else if (wr_s && sel_mt_hi_s) begin
            mtime_nxt_s = {wdata, mtime_r[31:0]};
        end else if (tick_s) begin
            mtime_nxt_s = mtime_r + 64'd1;
        end else begin
            mtime_nxt_s = mtime_r;
        end
        if (wr_s && sel_cmp_lo_s) begin
            mtimecmp_nxt_s = {mtimecmp_r[63:32], wdata};
        end else if (wr_s && sel_cmp_hi_s) begin
            mtimecmp_nxt_s = {wdata, mtimecmp_r[31:0]};
        end else begin
            mtimecmp_nxt_s = mtimecmp_r;
        end
        if (wr_s && sel_msip_s) begin
            msip_nxt_s = wdata[0];
        end else begin
            msip_nxt_s = msip_r;
        end
    end

    // Architectural state and prescaler.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            presc_r    <= CNT_W'(0);
            mtime_r    <= 64'h0000_0000_0000_0000;
            mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
            msip_r     <= 1'b0;
        end else begin
            presc_r    <= presc_nxt_s;
            mtime_r    <= mtime_nxt_s;
            mtimecmp_r <= mtimecmp_nxt_s;
            msip_r     <= msip_nxt_s;
        end
    end

    // Bus response and timer compare; the compare uses already-updated registers.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            tmr_irq_r   <= 1'b0;
        end else begin
            rsp_valid_r <= req;
            rsp_err_r   <= req & ~hit_s;
            rsp_rdata_r <= (req && !write && hit_s) ? rdata_s : 32'h0000_0000;
            tmr_irq_r   <= (mtime_r >= mtimecmp_r);
        end
    end

    assign rsp_valid          = rsp_valid_r;
    assign rsp_err            = rsp_err_r;
    assign rsp_rdata          = rsp_rdata_r;
    assign software_interrupt = msip_r;
    assign timer_interrupt    = tmr_irq_r;

endmodule

// File: tb/tb_clint.sv
// Bench for clint: two instances (TICK_DIV=4 and TICK_DIV=1) share stimulus and are
// compared every cycle against a cycle-level register-map model, plus literal pins.
module tb_clint;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        req;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rv [2];
    logic        re [2];
    logic        sw [2];
    logic        ti [2];
    logic [31:0] rd [2];

    always #5 clk = ~clk;

    clint #(.TICK_DIV(4), .BASE_ADDR(BASE)) dut_div4 (
        .clk(clk), .rst_b(rst_b), .req(req), .write(write), .addr(addr), .wdata(wdata),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(re[0]),
        .software_interrupt(sw[0]), .timer_interrupt(ti[0])
    );

    clint #(.TICK_DIV(1), .BASE_ADDR(BASE)) dut_div1 (
        .clk(clk), .rst_b(rst_b), .req(req), .write(write), .addr(addr), .wdata(wdata),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(re[1]),
        .software_interrupt(sw[1]), .timer_interrupt(ti[1])
    );

    // Model state per instance
    logic [63:0] m_mt   [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];
    int unsigned m_cyc  [2];
    logic        e_rv [2];
    logic        e_re [2];
    logic        e_sw [2];
    logic        e_ti [2];
    logic [31:0] e_rd [2];

    int vectors = 0;
    int miscompares = 0;

    function automatic int unsigned div_of(input int d);
        return (d == 0) ? 4 : 1;
    endfunction

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            logic [31:0] off;
            logic [31:0] val;
            int          sel;
            logic        tick;
            logic        wr;
            if (!rst_b) begin
                e_rv[d] = 1'b0; e_re[d] = 1'b0; e_rd[d] = 32'h0;
                e_sw[d] = 1'b0; e_ti[d] = 1'b0;
                m_mt[d] = 64'h0; m_cmp[d] = '1; m_msip[d] = 1'b0; m_cyc[d] = 0;
            end else begin
                off = addr - BASE;
                sel = 0;
                val = 32'h0;
                if (off < 32'h0001_0000) begin
                    case (off & 32'h0000_FFFC)
                        32'h0000_0000: begin sel = 1; val = {31'h0, m_msip[d]}; end
                        32'h0000_4000: begin sel = 2; val = m_cmp[d][31:0]; end
                        32'h0000_4004: begin sel = 3; val = m_cmp[d][63:32]; end
                        32'h0000_BFF8: begin sel = 4; val = m_mt[d][31:0]; end
                        32'h0000_BFFC: begin sel = 5; val = m_mt[d][63:32]; end
                        default:       sel = 0;
                    endcase
                end
                e_ti[d] = (m_mt[d] >= m_cmp[d]);
                e_rv[d] = req;
                e_re[d] = req && (sel == 0);
                e_rd[d] = (req && !write && sel != 0) ? val : 32'h0;
                tick = ((m_cyc[d] % div_of(d)) == div_of(d) - 1);
                m_cyc[d]++;
                wr = req && write;
                if (wr && sel == 1) m_msip[d] = wdata[0];
                if (wr && sel == 2) m_cmp[d][31:0] = wdata;
                if (wr && sel == 3) m_cmp[d][63:32] = wdata;
                if (wr && sel == 4) m_mt[d][31:0] = wdata;
                else if (wr && sel == 5) m_mt[d][63:32] = wdata;
                else if (tick) m_mt[d] = m_mt[d] + 64'd1;
                e_sw[d] = m_msip[d];
            end
        end
    endtask

    // Drive one cycle, step the model, then compare the following cycle's outputs.
    task automatic cyc(input logic r, input logic q, input logic w, input logic [31:0] a, input logic [31:0] dt);
        rst_b = r; req = q; write = w; addr = a; wdata = dt;
        model_step();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rsp_valid", d, 32'(rv[d]), 32'(e_rv[d]));
            check("rsp_err",   d, 32'(re[d]), 32'(e_re[d]));
            check("rsp_rdata", d, rd[d], e_rd[d]);
            check("sw_irq",    d, 32'(sw[d]), 32'(e_sw[d]));
            check("tmr_irq",   d, 32'(ti[d]), 32'(e_ti[d]));
        end
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic rd_reg(input logic [31:0] a);
        cyc(1'b1, 1'b1, 1'b0, a, $urandom);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] dt);
        cyc(1'b1, 1'b1, 1'b1, a, dt);
    endtask

    initial begin
        rst_b = 1'b0; req = 1'b0; write = 1'b0; addr = 32'h0; wdata = 32'h0;
        // Requests during reset must not respond
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'(i), BASE + 32'h4000, $urandom);

        // Reset values (cycle 0..3 after reset)
        rd_reg(BASE + 32'h4000);
        check("pin_cmp_lo_rst", 0, rd[0], 32'hFFFF_FFFF);
        check("pin_cmp_lo_rst", 1, rd[1], 32'hFFFF_FFFF);
        check("pin_tmr_rst", 1, 32'(ti[1]), 32'h0);
        rd_reg(BASE + 32'h4004);
        check("pin_cmp_hi_rst", 0, rd[0], 32'hFFFF_FFFF);
        rd_reg(BASE + 32'h0000);
        check("pin_msip_rst", 0, rd[0], 32'h0);
        check("pin_sw_rst", 0, 32'(sw[0]), 32'h0);
        rd_reg(BASE + 32'hBFF8);
        check("pin_mtime_rst", 0, rd[0], 32'h0);
        for (int i = 4; i < 40; i++) idle();
        // 40 cycles of free run
        rd_reg(BASE + 32'hBFF8);
        check("pin_mtime_div4", 0, rd[0], 32'd10);
        check("pin_mtime_div1", 1, rd[1], 32'd40);

        // Timer compare at 20 with mtime restarted from 0
        wr_reg(BASE + 32'h4004, 32'h0);
        wr_reg(BASE + 32'h4000, 32'd20);
        wr_reg(BASE + 32'hBFFC, 32'h0);
        wr_reg(BASE + 32'hBFF8, 32'h0);
        for (int i = 2; i <= 23; i++) begin
            idle();
            if (i == 21) check("pin_tmr_before", 1, 32'(ti[1]), 32'h0);
            if (i == 22) check("pin_tmr_rise", 1, 32'(ti[1]), 32'h1);
        end
        wr_reg(BASE + 32'h4000, 32'hFFFF_FFFF);
        check("pin_tmr_hold", 1, 32'(ti[1]), 32'h1);
        idle();
        check("pin_tmr_fall", 1, 32'(ti[1]), 32'h0);

        // msip
        wr_reg(BASE + 32'h0000, 32'hFFFF_FFFF);
        check("pin_sw_set", 0, 32'(sw[0]), 32'h1);
        check("pin_sw_set", 1, 32'(sw[1]), 32'h1);
        rd_reg(BASE + 32'h0000);
        check("pin_msip_rd", 0, rd[0], 32'h1);
        wr_reg(BASE + 32'h0000, 32'hFFFF_FFFE);
        check("pin_sw_clr", 1, 32'(sw[1]), 32'h0);

        // 64-bit wrap on the TICK_DIV=1 instance
        wr_reg(BASE + 32'hBFFC, 32'hFFFF_FFFF);
        wr_reg(BASE + 32'hBFF8, 32'hFFFF_FFFE);
        idle();
        idle();
        rd_reg(BASE + 32'hBFF8);
        check("pin_wrap_lo", 1, rd[1], 32'h0);
        rd_reg(BASE + 32'hBFFC);
        check("pin_wrap_hi", 1, rd[1], 32'h0);

        // Write colliding with a tick
        wr_reg(BASE + 32'hBFF8, 32'h1234_5678);
        rd_reg(BASE + 32'hBFF8);
        check("pin_collide", 1, rd[1], 32'h1234_5678);

        // Unmapped and out-of-window accesses
        rd_reg(BASE + 32'h1000);
        check("pin_unmapped_err", 0, 32'(re[0]), 32'h1);
        check("pin_unmapped_data", 0, rd[0], 32'h0);
        rd_reg(32'h0300_0000);
        check("pin_outside_err", 1, 32'(re[1]), 32'h1);
        wr_reg(32'h0300_0000, 32'hDEAD_BEEF);
        wr_reg(BASE + 32'h1000, 32'hDEAD_BEEF);
        wr_reg(BASE - 32'h4, 32'hDEAD_BEEF);
        rd_reg(BASE + 32'h4000);

        // Randomized traffic with occasional mid-run reset
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a;
            logic [31:0] dt;
            int          k;
            k = int'($urandom_range(0, 9));
            case (k)
                0:       begin a = BASE + 32'h0000; dt = $urandom; end
                1:       begin a = BASE + 32'h4000; dt = $urandom_range(0, 600); end
                2:       begin a = BASE + 32'h4004; dt = $urandom_range(0, 1); end
                3:       begin a = BASE + 32'hBFF8; dt = $urandom_range(0, 600); end
                4:       begin a = BASE + 32'hBFFC; dt = $urandom_range(0, 1); end
                5:       begin a = BASE + 32'(16'($urandom)); dt = $urandom; end
                6:       begin a = 32'h1000_0000 | $urandom; dt = $urandom; end
                default: begin a = BASE + 32'hBFF8; dt = $urandom; end
            endcase
            a = a | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 399) == 0) begin
                cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, dt);
            end else if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                cyc(1'b1, 1'b1, 1'($urandom_range(0, 1)), a, dt);
            end
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clint.md
# clint

Core-local interrupt source for the RV32 core. It holds a 64-bit `mtime` counter, a 64-bit `mtimecmp` compare register and the `msip` bit, and software reaches all three through a simple word-wide memory-mapped request/response port. It drives `software_interrupt` and `timer_interrupt` into the trap controller, which masks them with `mstatus`/`mie` and takes the trap. It sits beside the data-memory path on the core's peripheral bus.

## Interface
- `TICK_DIV`, 1 — number of `clk` cycles per `mtime` increment; must be ≥1.
- `BASE_ADDR`, 32'h0200_0000 — base address of the register block; the low 16 bits select the register.
- `clk`  in  1  — core clock.
- `rst_b`  in  1  — reset, synchronous, active-low. One clock, one reset.
- `req`  in  1  — bus request valid; single-cycle pulse per access.
- `write`  in  1  — 1 = write, 0 = read; qualified by `req`.
- `addr`  in  `XLEN  — byte address; bits [1:0] ignored.
- `wdata`  in  `XLEN  — write data; full-word writes only.
- `rsp_valid`  out  1  — response valid, exactly one cycle after each `req`.
- `rsp_rdata`  out  `XLEN  — read data; 0 for writes and unmapped addresses.
- `rsp_err`  out  1  — the access hit an address inside the 64 KB window that is not a register, or fell outside the window.
- `software_interrupt`  out  1  — level, equals `msip`.
- `timer_interrupt`  out  1  — level, `mtime >= mtimecmp` (unsigned 64-bit).

## Operation
- Register map, offsets from `BASE_ADDR`:
  - 0x0000 `msip`: bit 0 is read/write; bits 31:1 read as 0.
  - 0x4000 `mtimecmp[31:0]`; 0x4004 `mtimecmp[63:32]`.
  - 0xBFF8 `mtime[31:0]`; 0xBFFC `mtime[63:32]`.
- Reset values: `mtime` = 0, `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF, `msip` = 0, prescaler count = 0. All outputs are 0.
- Prescaler:
  - The counter runs 0..`TICK_DIV`-1. `tick` is asserted when it reaches `TICK_DIV`-1, and the counter then wraps to 0.
  - When `TICK_DIV`=1, `tick` is asserted every cycle.
- `mtime`:
  - Increments by 1 on each `tick`. It wraps from all-ones to 0 with no flag.
  - A write to either half replaces that half. The other half holds its value, and there is no carry between halves.
  - If a write and a `tick` land in the same cycle, the write wins and the increment is dropped for that cycle. The prescaler is not reset.
- `mtimecmp`: each half is written independently. No side effects on writes.
- Reads return the register value as it was before any same-cycle update.
- Unmapped accesses:
  - Any `req` whose address is outside [`BASE_ADDR`, `BASE_ADDR`+0xFFFF] or is not a listed offset sets `rsp_err`=1 with `rsp_rdata`=0.
  - A write to such an address changes no state.
- Interrupt outputs:
  - Both are registered.
  - `timer_interrupt` is computed from the post-update `mtime`/`mtimecmp` values, so it reflects every write and tick from the previous cycle.
  - Both are levels: they stay high until software clears `msip` or raises `mtimecmp`/lowers `mtime`. The block does no masking; masking belongs to the trap controller.

## Timing
- Bus access: `req` in cycle N gives `rsp_valid`=1 in cycle N+1, with `rsp_rdata`/`rsp_err` valid in N+1.
  - The port never stalls. Back-to-back `req` every cycle is legal and produces `rsp_valid` every cycle.
- A write in cycle N takes effect on the register at the N→N+1 edge.
- `software_interrupt` follows an `msip` write one cycle later: it is high in N+1.
- `timer_interrupt` is high in cycle N+2 after a write or tick in cycle N that makes `mtime >= mtimecmp`. The path is register update at N+1, then the registered compare.
- `rsp_valid`, `rsp_err` and `rsp_rdata` are 0 in any cycle without a preceding `req`.
- Reset mid-operation:
  - All state returns to its reset values on the next edge with `rst_b`=0.
  - A `req` issued in the reset cycle gets no response.

## Test plan
- Reset → `mtime`=0; `mtimecmp` reads 0xFFFF_FFFF at both halves; `msip`=0; `timer_interrupt`=0 and `software_interrupt`=0.
- `TICK_DIV`=4, free run 40 cycles after reset → `mtime[31:0]` reads 10. With `TICK_DIV`=1, 40 cycles → 40.
- Write `mtimecmp_hi`=0 then `mtimecmp_lo`=20 with `TICK_DIV`=1 → `timer_interrupt` rises exactly 2 cycles after `mtime` reaches 20. Then write `mtimecmp_lo`=0xFFFF_FFFF → `timer_interrupt` falls 2 cycles after that write.
- Write `msip`=1 at cycle N → `software_interrupt`=1 at N+1. Write `msip`=0 → it falls one cycle later. A read of `msip` with `wdata` bits 31:1 set returns 0x1.
- Wrap and collision:
  - Write `mtime_hi`=0xFFFF_FFFF, then `mtime_lo`=0xFFFF_FFFE → after 2 ticks `mtime` reads 0/0, and no carry occurs out of a write to `mtime_lo`.
  - A write coinciding with a tick → the read-back equals the written value.
- Read 0x0000_1000 offset and an address outside the window → `rsp_err`=1, `rsp_rdata`=0, one cycle after `req`. A write there leaves every register unchanged.
